// File: rtl/mario_tile_poller.sv
// mario_tile_poller
//
// Purpose:
//   Produces the four collision inputs of the Mario movement block. Each
//   sweep snapshots Mario's centre position and works out probe pixels just
//   outside his 40x40 box. Every probe is turned into a level-map tile
//   address and the tile RAM is read. The four tile codes are then committed
//   to the poll outputs together. Sweeps run back to back. The block also
//   owns the horizontal scroll column, which advances one tile per Shift
//   pulse. A Shift pulse aborts the sweep in flight.
//
// Ports:
//   Clk                 system clock
//   Reset               asynchronous reset, active low
//   Mario_X_Pos [9:0]   Mario centre X in pixels
//   Mario_Y_Pos [9:0]   Mario centre Y in pixels
//   Shift               one-cycle scroll pulse from the Mario block
//   tile_data   [2:0]   tile RAM read data, valid one cycle after tile_rd
//   tile_addr   [10:0]  tile RAM address {row[3:0], col[6:0]}
//   tile_rd             tile RAM read strobe
//   mario_poll_up/down/left/right [2:0]  committed tile codes, 0 = air
//   scroll_col  [6:0]   map column shown at the left playfield edge
//   sweep_done          one-cycle pulse, high while freshly committed polls
//                       first appear on the outputs
//
// Configuration macro:
//   POLL_CORNER_EN - when defined, each direction probes the two corners of
//   its edge (8 probes, 11-cycle sweep). The first corner's code is reported
//   when it is nonzero, otherwise the second corner's code. When the macro is
//   undefined, each direction uses one centre probe (4 probes, 7-cycle sweep).

module mario_tile_poller #(
    parameter int         X_MIN         = 120,
    parameter int         X_MAX         = 519,
    parameter int         Y_MIN         = 40,
    parameter int         Y_MAX         = 439,
    parameter int         HALF_SIZE     = 20,
    parameter int         PROBE_GAP     = 2,
    parameter int         TILE_SIZE     = 40,
    parameter int         MAP_COLS_LOG2 = 7,
    parameter logic [2:0] BOUNDARY_CODE = 3'b001
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [9:0]                 Mario_X_Pos,
    input  logic [9:0]                 Mario_Y_Pos,
    input  logic                       Shift,
    input  logic [2:0]                 tile_data,
    output logic [MAP_COLS_LOG2+3:0]   tile_addr,
    output logic                       tile_rd,
    output logic [2:0]                 mario_poll_up,
    output logic [2:0]                 mario_poll_down,
    output logic [2:0]                 mario_poll_left,
    output logic [2:0]                 mario_poll_right,
    output logic [MAP_COLS_LOG2-1:0]   scroll_col,
    output logic                       sweep_done
);

`ifdef POLL_CORNER_EN
    localparam int NPROBE = 8;
    localparam int IDX_W  = 3;
`else
    localparam int NPROBE = 4;
    localparam int IDX_W  = 2;
`endif

    // Offsets of the probe pixels from Mario's centre. They are 11 bits wide,
    // so a probe left of or above pixel 0 wraps to a large value. That value
    // then fails the upper playfield bound.
    localparam logic [10:0] OUT_NEAR = 11'(HALF_SIZE + PROBE_GAP);
    localparam logic [10:0] OUT_FAR  = 11'(HALF_SIZE + PROBE_GAP - 1);
    localparam logic [10:0] EDGE_LO  = 11'(HALF_SIZE);
    localparam logic [10:0] EDGE_HI  = 11'(HALF_SIZE - 1);

    typedef enum logic [3:0] {
        SNAP,
        P0,
        P1,
        P2,
        P3,
`ifdef POLL_CORNER_EN
        P4,
        P5,
        P6,
        P7,
`endif
        DRAIN,
        COMMIT
    } state_t;

    state_t                      state_q, state_d;
    logic [9:0]                  xSnap_q, ySnap_q;
    logic [MAP_COLS_LOG2-1:0]    scrollCol_q, scrollCol_d;
    logic [2:0]                  shadow_q [NPROBE];
    logic                        prevInRange_q;
    logic [2:0]                  pollUp_q, pollDown_q, pollLeft_q, pollRight_q;
    logic                        sweepDone_q;

    logic                        isProbe;
    logic [IDX_W-1:0]            probeIdx;
    logic                        captureEn;
    logic [IDX_W-1:0]            captureIdx;
    logic [2:0]                  captureData;
    logic [10:0]                 xs, ys, probeX, probeY, relX, relY;
    logic                        probeInRange;
    logic [MAP_COLS_LOG2-1:0]    tileCol;
    logic [3:0]                  tileRow;
    logic [2:0]                  commitUp, commitDown, commitLeft, commitRight;

    // Sweep sequencing. A Shift pulse sends the FSM back to SNAP from any
    // state. COMMIT already goes to SNAP, so a commit in progress still
    // completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SNAP:    state_d = P0;
            P0:      state_d = P1;
            P1:      state_d = P2;
            P2:      state_d = P3;
`ifdef POLL_CORNER_EN
            P3:      state_d = P4;
            P4:      state_d = P5;
            P5:      state_d = P6;
            P6:      state_d = P7;
            P7:      state_d = DRAIN;
`else
            P3:      state_d = DRAIN;
`endif
            DRAIN:   state_d = COMMIT;
            COMMIT:  state_d = SNAP;
            default: state_d = SNAP;
        endcase
        if (Shift) begin
            state_d = SNAP;
        end
    end

    // Map each probe state to the probe it addresses. The read data for the
    // previous probe arrives one cycle later, so it is captured in the
    // following state. DRAIN catches the data for the last probe.
    always_comb begin
        isProbe    = 1'b0;
        probeIdx   = '0;
        captureEn  = 1'b0;
        captureIdx = '0;
        case (state_q)
            P0:    begin isProbe = 1'b1; probeIdx = IDX_W'(0); end
            P1:    begin isProbe = 1'b1; probeIdx = IDX_W'(1); captureEn = 1'b1; captureIdx = IDX_W'(0); end
            P2:    begin isProbe = 1'b1; probeIdx = IDX_W'(2); captureEn = 1'b1; captureIdx = IDX_W'(1); end
            P3:    begin isProbe = 1'b1; probeIdx = IDX_W'(3); captureEn = 1'b1; captureIdx = IDX_W'(2); end
`ifdef POLL_CORNER_EN
            P4:    begin isProbe = 1'b1; probeIdx = IDX_W'(4); captureEn = 1'b1; captureIdx = IDX_W'(3); end
            P5:    begin isProbe = 1'b1; probeIdx = IDX_W'(5); captureEn = 1'b1; captureIdx = IDX_W'(4); end
            P6:    begin isProbe = 1'b1; probeIdx = IDX_W'(6); captureEn = 1'b1; captureIdx = IDX_W'(5); end
            P7:    begin isProbe = 1'b1; probeIdx = IDX_W'(7); captureEn = 1'b1; captureIdx = IDX_W'(6); end
`endif
            DRAIN: begin captureEn = 1'b1; captureIdx = IDX_W'(NPROBE - 1); end
            default: ;
        endcase
    end

    // Probe pixel coordinates, taken from the snapshot so that one sweep
    // never mixes two positions.
    always_comb begin
        xs     = {1'b0, xSnap_q};
        ys     = {1'b0, ySnap_q};
        probeX = xs;
        probeY = ys;
`ifdef POLL_CORNER_EN
        case (probeIdx)
            3'd0:    begin probeX = xs - EDGE_LO;  probeY = ys - OUT_NEAR; end
            3'd1:    begin probeX = xs + EDGE_HI;  probeY = ys - OUT_NEAR; end
            3'd2:    begin probeX = xs - EDGE_LO;  probeY = ys + OUT_FAR;  end
            3'd3:    begin probeX = xs + EDGE_HI;  probeY = ys + OUT_FAR;  end
            3'd4:    begin probeX = xs - OUT_NEAR; probeY = ys - EDGE_LO;  end
            3'd5:    begin probeX = xs - OUT_NEAR; probeY = ys + EDGE_HI;  end
            3'd6:    begin probeX = xs + OUT_FAR;  probeY = ys - EDGE_LO;  end
            default: begin probeX = xs + OUT_FAR;  probeY = ys + EDGE_HI;  end
        endcase
`else
        case (probeIdx)
            2'd0:    probeY = ys - OUT_NEAR;
            2'd1:    probeY = ys + OUT_FAR;
            2'd2:    probeX = xs - OUT_NEAR;
            default: probeX = xs + OUT_FAR;
        endcase
`endif
    end

    // Range test and tile address. The column is offset by the scroll column
    // and wraps around the 128-wide map.
    always_comb begin
        probeInRange = (probeX >= 11'(X_MIN)) && (probeX <= 11'(X_MAX)) &&
                       (probeY >= 11'(Y_MIN)) && (probeY <= 11'(Y_MAX));
        relX         = probeX - 11'(X_MIN);
        relY         = probeY - 11'(Y_MIN);
        tileCol      = MAP_COLS_LOG2'(relX / 11'(TILE_SIZE)) + scrollCol_q;
        tileRow      = 4'(relY / 11'(TILE_SIZE));
        tile_rd      = isProbe && probeInRange;
        tile_addr    = tile_rd ? {tileRow, tileCol} : '0;
        captureData  = prevInRange_q ? tile_data : BOUNDARY_CODE;
    end

    // Per-direction result. In corner mode the first corner wins when it is
    // solid.
    always_comb begin
`ifdef POLL_CORNER_EN
        commitUp    = (shadow_q[0] != 3'd0) ? shadow_q[0] : shadow_q[1];
        commitDown  = (shadow_q[2] != 3'd0) ? shadow_q[2] : shadow_q[3];
        commitLeft  = (shadow_q[4] != 3'd0) ? shadow_q[4] : shadow_q[5];
        commitRight = (shadow_q[6] != 3'd0) ? shadow_q[6] : shadow_q[7];
`else
        commitUp    = shadow_q[0];
        commitDown  = shadow_q[1];
        commitLeft  = shadow_q[2];
        commitRight = shadow_q[3];
`endif
    end

    always_comb begin
        scrollCol_d = Shift ? scrollCol_q + 1'b1 : scrollCol_q;
    end

    // State, snapshot, shadow and output registers. An aborted sweep leaves
    // stale shadows behind. They are harmless because a later sweep
    // overwrites every shadow before it reaches COMMIT.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= SNAP;
            xSnap_q       <= '0;
            ySnap_q       <= '0;
            scrollCol_q   <= '0;
            prevInRange_q <= 1'b0;
            for (int i = 0; i < NPROBE; i++) begin
                shadow_q[i] <= '0;
            end
            pollUp_q      <= '0;
            pollDown_q    <= '0;
            pollLeft_q    <= '0;
            pollRight_q   <= '0;
            sweepDone_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            scrollCol_q <= scrollCol_d;
            sweepDone_q <= (state_q == COMMIT);
            if (state_q == SNAP) begin
                xSnap_q <= Mario_X_Pos;
                ySnap_q <= Mario_Y_Pos;
            end
            if (isProbe) begin
                prevInRange_q <= probeInRange;
            end
            if (captureEn) begin
                shadow_q[captureIdx] <= captureData;
            end
            if (state_q == COMMIT) begin
                pollUp_q    <= commitUp;
                pollDown_q  <= commitDown;
                pollLeft_q  <= commitLeft;
                pollRight_q <= commitRight;
            end
        end
    end

    assign mario_poll_up    = pollUp_q;
    assign mario_poll_down  = pollDown_q;
    assign mario_poll_left  = pollLeft_q;
    assign mario_poll_right = pollRight_q;
    assign scroll_col       = scrollCol_q;
    assign sweep_done       = sweepDone_q;

endmodule

// File: tb/tb_mario_tile_poller.sv
// tb_mario_tile_poller
//
// Directed testbench for mario_tile_poller in its default build (one centre
// probe per direction). A small registered tile RAM model answers the reads.
// Each step advances to a falling clock edge and compares the outputs with
// hand-computed expected values.
//
// Address arithmetic behind the expected values, for X=140 and Y=399:
//   up    (140,377) -> row 8, col 0 -> 1024
//   down  (140,420) -> row 9, col 0 -> 1152
//   left  (118,399) -> out of range -> code 3'b001
//   right (161,399) -> row 8, col 1 -> 1025
// The scroll column adds to the column index.

module tb_mario_tile_poller;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  Mario_X_Pos;
    logic [9:0]  Mario_Y_Pos;
    logic        Shift;
    logic [2:0]  tile_data;
    logic [10:0] tile_addr;
    logic        tile_rd;
    logic [2:0]  mario_poll_up;
    logic [2:0]  mario_poll_down;
    logic [2:0]  mario_poll_left;
    logic [2:0]  mario_poll_right;
    logic [6:0]  scroll_col;
    logic        sweep_done;

    int compared;
    int mismatched;
    logic [2:0] mem [2048];
    logic sawDone;

    mario_tile_poller dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Mario_X_Pos      (Mario_X_Pos),
        .Mario_Y_Pos      (Mario_Y_Pos),
        .Shift            (Shift),
        .tile_data        (tile_data),
        .tile_addr        (tile_addr),
        .tile_rd          (tile_rd),
        .mario_poll_up    (mario_poll_up),
        .mario_poll_down  (mario_poll_down),
        .mario_poll_left  (mario_poll_left),
        .mario_poll_right (mario_poll_right),
        .scroll_col       (scroll_col),
        .sweep_done       (sweep_done)
    );

    // Free-running clock with a 10-time-unit period.
    always #5 Clk = ~Clk;

    // Tile RAM model with one cycle of read latency.
    always @(posedge Clk) begin
        if (tile_rd) begin
            tile_data <= mem[tile_addr];
        end
    end

    // Moves to the next falling edge, midway between active edges.
    task automatic tick();
        @(negedge Clk);
    endtask

    // One comparison: the observed value must match the expected value exactly.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 3'd0;
        end
        mem[1152] = 3'b010;
        mem[1158] = 3'b100;

        // Hold the design in reset.
        Reset       = 1'b0;
        Shift       = 1'b0;
        Mario_X_Pos = 10'd140;
        Mario_Y_Pos = 10'd399;
        tick();
        tick();
        checkOutput("rst_poll_down", 32'(mario_poll_down), 32'd0);
        checkOutput("rst_poll_left", 32'(mario_poll_left), 32'd0);
        checkOutput("rst_scroll", 32'(scroll_col), 32'd0);
        checkOutput("rst_addr", 32'(tile_addr), 32'd0);
        checkOutput("rst_rd", 32'(tile_rd), 32'd0);
        checkOutput("rst_done", 32'(sweep_done), 32'd0);

        // First sweep after reset release.
        Reset = 1'b1;
        tick();
        checkOutput("s1_p0_addr", 32'(tile_addr), 32'd1024);
        checkOutput("s1_p0_rd", 32'(tile_rd), 32'd1);
        tick();
        checkOutput("s1_p1_addr", 32'(tile_addr), 32'd1152);
        checkOutput("s1_p1_rd", 32'(tile_rd), 32'd1);
        tick();
        checkOutput("s1_p2_rd", 32'(tile_rd), 32'd0);
        tick();
        checkOutput("s1_p3_addr", 32'(tile_addr), 32'd1025);
        checkOutput("s1_p3_rd", 32'(tile_rd), 32'd1);
        tick();
        checkOutput("s1_drain_rd", 32'(tile_rd), 32'd0);
        tick();
        checkOutput("s1_commit_done", 32'(sweep_done), 32'd0);
        checkOutput("s1_commit_down_old", 32'(mario_poll_down), 32'd0);
        tick();
        checkOutput("s1_done", 32'(sweep_done), 32'd1);
        checkOutput("s1_poll_up", 32'(mario_poll_up), 32'd0);
        checkOutput("s1_poll_down", 32'(mario_poll_down), 32'd2);
        checkOutput("s1_poll_left", 32'(mario_poll_left), 32'd1);
        checkOutput("s1_poll_right", 32'(mario_poll_right), 32'd0);
        tick();
        checkOutput("s2_p0_done", 32'(sweep_done), 32'd0);
        repeat (5) tick();
        checkOutput("s2_commit_done", 32'(sweep_done), 32'd0);
        tick();
        checkOutput("s2_done_period7", 32'(sweep_done), 32'd1);

        // Scroll to column 5, then pulse once more to reach column 6.
        Shift = 1'b1;
        repeat (5) tick();
        checkOutput("shift_scroll5", 32'(scroll_col), 32'd5);
        checkOutput("shift_no_done", 32'(sweep_done), 32'd0);
        checkOutput("shift_keep_down", 32'(mario_poll_down), 32'd2);
        tick();
        checkOutput("shift_scroll6", 32'(scroll_col), 32'd6);
        Shift = 1'b0;
        tick();
        checkOutput("sc6_up_addr", 32'(tile_addr), 32'd1030);
        tick();
        checkOutput("sc6_down_addr", 32'(tile_addr), 32'd1158);
        repeat (4) tick();
        tick();
        checkOutput("sc6_done", 32'(sweep_done), 32'd1);
        checkOutput("sc6_poll_down", 32'(mario_poll_down), 32'd4);

        // Abort a sweep at P2 and keep scrolling up to column 127.
        tick();
        tick();
        tick();
        Shift   = 1'b1;
        sawDone = 1'b0;
        repeat (121) begin
            tick();
            if (sweep_done) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);
        checkOutput("scroll127", 32'(scroll_col), 32'd127);
        checkOutput("abort_keep_down", 32'(mario_poll_down), 32'd4);
        tick();
        checkOutput("scroll_wrap0", 32'(scroll_col), 32'd0);
        Shift = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checkOutput("wrap_right_addr", 32'(tile_addr), 32'd1025);
        checkOutput("wrap_right_rd", 32'(tile_rd), 32'd1);
        tick();
        tick();
        tick();
        checkOutput("wrap_done", 32'(sweep_done), 32'd1);
        checkOutput("wrap_poll_down", 32'(mario_poll_down), 32'd2);

        // Change X mid-sweep; the sweep in flight keeps its snapshot X=140.
        tick();
        tick();
        Mario_X_Pos = 10'd142;
        tick();
        checkOutput("midx_left_rd_old", 32'(tile_rd), 32'd0);
        repeat (3) tick();
        tick();
        checkOutput("midx_poll_left_old", 32'(mario_poll_left), 32'd1);
        checkOutput("midx_done1", 32'(sweep_done), 32'd1);
        repeat (3) tick();
        checkOutput("midx_left_rd_new", 32'(tile_rd), 32'd1);
        checkOutput("midx_left_addr_new", 32'(tile_addr), 32'd1024);
        repeat (3) tick();
        tick();
        checkOutput("midx_poll_left_new", 32'(mario_poll_left), 32'd0);
        checkOutput("midx_poll_down_new", 32'(mario_poll_down), 32'd2);

        // Move to scroll column 1, then assert reset during P2.
        Shift = 1'b1;
        tick();
        Shift = 1'b0;
        checkOutput("pre_rst_scroll1", 32'(scroll_col), 32'd1);
        tick();
        checkOutput("pre_rst_up_addr", 32'(tile_addr), 32'd1025);
        tick();
        tick();
        Reset = 1'b0;
        #1;
        checkOutput("midrst_poll_down", 32'(mario_poll_down), 32'd0);
        checkOutput("midrst_scroll", 32'(scroll_col), 32'd0);
        checkOutput("midrst_rd", 32'(tile_rd), 32'd0);
        checkOutput("midrst_addr", 32'(tile_addr), 32'd0);
        tick();
        Reset = 1'b1;
        tick();
        checkOutput("rerun_up_addr", 32'(tile_addr), 32'd1024);
        checkOutput("rerun_up_rd", 32'(tile_rd), 32'd1);
        tick();
        checkOutput("rerun_down_addr", 32'(tile_addr), 32'd1152);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
